// File: rtl/my_struct_package.sv
// Shared types for the cache access sequencer: command codes, FSM states
// and decode helpers. The CACHE_SEQ_SNOOP_EN macro decides whether the
// invalidate/snoop codes run a real lookup or are rejected as illegal.
package my_struct_package;

  localparam int CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    READ_D  = 4'd0,
    WRITE_D = 4'd1,
    FETCH_I = 4'd2,
    INVAL   = 4'd3,
    SNOOP   = 4'd4,
    CLEAR   = 4'd8,
    PRINT   = 4'd9
  } cmd_code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_UPDATE,
    S_CLEAR,
    S_PRINT,
    S_FINISH
  } seq_state_t;

  // Codes that always update the cache and feed hit/miss statistics
  function automatic logic is_stat(input logic [CMD_W-1:0] c);
    return (c == READ_D) || (c == WRITE_D) || (c == FETCH_I);
  endfunction

  // Codes that run the read_enable lookup phase
  function automatic logic is_lookup(input logic [CMD_W-1:0] c);
`ifdef CACHE_SEQ_SNOOP_EN
    return is_stat(c) || (c == INVAL) || (c == SNOOP);
`else
    return is_stat(c);
`endif
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Clear wins over increment; hold once every bit is set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cache_access_sequencer.sv
// Steps one trace command at a time through lookup/update phases on the
// split L1 caches (data 8-way, instruction 4-way), issues clear/print
// requests and keeps saturating hit/miss statistics.
// Optional: CACHE_SEQ_SNOOP_EN enables the invalidate/snoop lookup path.
module cache_access_sequencer
  import my_struct_package::*;
#(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32,
  parameter int LOOKUP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_n,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              hit,
  input  logic              hitM,
  output logic              sel_d,
  output logic              sel_i,
  output logic              read_enable,
  output logic              write_enable,
  output logic [ADDR_W-1:0] addr_out,
  output logic              clear_req,
  output logic              print_req,
  output logic              done,
  output logic              illegal,
  output logic [CNT_W-1:0]  read_cnt,
  output logic [CNT_W-1:0]  write_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int LAT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LOOKUP_LAT - 1);

  seq_state_t       state;
  logic [CMD_W-1:0] code_q;
  logic [LAT_W-1:0] lat_cnt;

  logic accept, lookup_last, stat_sample;
  logic rd_inc, wr_inc, hit_inc, miss_inc, cnt_clr;

  // hitM is carried to the MESI FSM by the caches themselves; the
  // sequencer has no decision that depends on it yet.
  logic unused_hitm;
  assign unused_hitm = hitM;

  assign accept      = (state == S_IDLE) && cmd_valid && cmd_ready;
  assign lookup_last = (state == S_LOOKUP) && (lat_cnt == LAT_LAST);
  assign stat_sample = lookup_last && is_stat(code_q);

  assign rd_inc   = accept && ((cmd_n == READ_D) || (cmd_n == FETCH_I));
  assign wr_inc   = accept && (cmd_n == WRITE_D);
  assign hit_inc  = stat_sample && hit;
  assign miss_inc = stat_sample && !hit;
  assign cnt_clr  = accept && (cmd_n == CLEAR);

  // Command FSM; every strobe is registered and set on entry to its state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      code_q       <= '0;
      lat_cnt      <= '0;
      cmd_ready    <= 1'b1;
      sel_d        <= 1'b0;
      sel_i        <= 1'b0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      addr_out     <= '0;
      clear_req    <= 1'b0;
      print_req    <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            code_q    <= cmd_n;
            addr_out  <= cmd_addr;
            cmd_ready <= 1'b0;
            lat_cnt   <= '0;
            if (is_lookup(cmd_n)) begin
              state       <= S_LOOKUP;
              read_enable <= 1'b1;
              sel_i       <= (cmd_n == FETCH_I);
              sel_d       <= (cmd_n != FETCH_I);
            end else if (cmd_n == CLEAR) begin
              state        <= S_CLEAR;
              clear_req    <= 1'b1;
              write_enable <= 1'b1;
              sel_d        <= 1'b1;
              sel_i        <= 1'b1;
            end else if (cmd_n == PRINT) begin
              state     <= S_PRINT;
              print_req <= 1'b1;
            end else begin
              state   <= S_FINISH;
              done    <= 1'b1;
              illegal <= 1'b1;
            end
          end
        end
        S_LOOKUP: begin
          if (lat_cnt == LAT_LAST) begin
            read_enable <= 1'b0;
            // Invalidate/snoop only touch the line when it is present
            if (is_stat(code_q) || hit) begin
              state        <= S_UPDATE;
              write_enable <= 1'b1;
            end else begin
              state <= S_FINISH;
              done  <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_UPDATE: begin
          write_enable <= 1'b0;
          state        <= S_FINISH;
          done         <= 1'b1;
        end
        S_CLEAR: begin
          clear_req    <= 1'b0;
          write_enable <= 1'b0;
          state        <= S_FINISH;
          done         <= 1'b1;
        end
        S_PRINT: begin
          print_req <= 1'b0;
          state     <= S_FINISH;
          done      <= 1'b1;
        end
        S_FINISH: begin
          done      <= 1'b0;
          illegal   <= 1'b0;
          sel_d     <= 1'b0;
          sel_i     <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_read_cnt (
    .clk(clk), .rst(rst), .inc(rd_inc), .clr(cnt_clr), .cnt(read_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_write_cnt (
    .clk(clk), .rst(rst), .inc(wr_inc), .clr(cnt_clr), .cnt(write_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk(clk), .rst(rst), .inc(hit_inc), .clr(cnt_clr), .cnt(hit_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk(clk), .rst(rst), .inc(miss_inc), .clr(cnt_clr), .cnt(miss_cnt)
  );

endmodule

// File: tb/tb_cache_access_sequencer.sv
// Scoreboard bench for cache_access_sequencer: each command pushes its
// expected strobe profile, then the done pulse pops and compares it.
module tb_cache_access_sequencer;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 2;
  localparam int LAT    = 1;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef CACHE_SEQ_SNOOP_EN
  localparam bit SNOOP_EN = 1'b1;
`else
  localparam bit SNOOP_EN = 1'b0;
`endif

  logic              clk, rst;
  logic              cmd_valid, cmd_ready;
  logic [3:0]        cmd_n;
  logic [ADDR_W-1:0] cmd_addr, addr_out;
  logic              hit, hitM;
  logic              sel_d, sel_i, read_enable, write_enable;
  logic              clear_req, print_req, done, illegal;
  logic [CNT_W-1:0]  read_cnt, write_cnt, hit_cnt, miss_cnt;

  cache_access_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .LOOKUP_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_n(cmd_n), .cmd_addr(cmd_addr), .hit(hit), .hitM(hitM),
    .sel_d(sel_d), .sel_i(sel_i), .read_enable(read_enable),
    .write_enable(write_enable), .addr_out(addr_out), .clear_req(clear_req),
    .print_req(print_req), .done(done), .illegal(illegal),
    .read_cnt(read_cnt), .write_cnt(write_cnt), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                lat;
    bit                ill;
    int                re;
    int                we;
    int                clr;
    int                prt;
    bit                sd;
    bit                si;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int   m_rd, m_wr, m_hit, m_miss;
  int   n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // Reference model: expected profile of one command plus counter update
  task automatic push_exp(input logic [3:0] code, input logic [ADDR_W-1:0] a, input bit h);
    exp_t e;
    bit   lk;
    e = '{lat: 0, ill: 0, re: 0, we: 0, clr: 0, prt: 0, sd: 0, si: 0, addr: a};
    lk = (code <= 4'd2) || (SNOOP_EN && (code == 4'd3 || code == 4'd4));
    if (lk) begin
      e.re  = LAT;
      e.we  = (code <= 4'd2 || h) ? 1 : 0;
      e.lat = LAT + 1 + e.we;
      e.sd  = (code != 4'd2);
      e.si  = (code == 4'd2);
      if (code == 4'd0 || code == 4'd2) m_rd = sat_inc(m_rd);
      if (code == 4'd1) m_wr = sat_inc(m_wr);
      if (code <= 4'd2) begin
        if (h) m_hit = sat_inc(m_hit);
        else   m_miss = sat_inc(m_miss);
      end
    end else if (code == 4'd8) begin
      e.we = 1; e.clr = 1; e.lat = 2; e.sd = 1; e.si = 1;
      m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
    end else if (code == 4'd9) begin
      e.prt = 1; e.lat = 2;
    end else begin
      e.ill = 1; e.lat = 1;
    end
    sb.push_back(e);
  endtask

  // Entered and left on a falling edge; the next command may follow at once
  task automatic run_cmd(input logic [3:0] code, input logic [ADDR_W-1:0] a, input bit h);
    exp_t e;
    int re_n, we_n, clr_n, prt_n, ovl, lat;
    bit sd1, si1, ill_o, got;
    logic [ADDR_W-1:0] a_o;
    re_n = 0; we_n = 0; clr_n = 0; prt_n = 0; ovl = 0; lat = 0;
    sd1 = 0; si1 = 0; ill_o = 0; got = 0; a_o = '0;
    chk("ready_before", cmd_ready, 1);
    cmd_valid = 1; cmd_n = code; cmd_addr = a; hit = h; hitM = h;
    push_exp(code, a, h);
    for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        cmd_valid = 0;
        sd1 = sel_d;
        si1 = sel_i;
      end
      re_n  += int'(read_enable);
      we_n  += int'(write_enable);
      clr_n += int'(clear_req);
      prt_n += int'(print_req);
      if (read_enable && write_enable) ovl++;
      if (done) begin
        got = 1; lat = cyc; ill_o = illegal; a_o = addr_out;
      end
    end
    chk("done_seen", got, 1);
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("illegal", ill_o, e.ill);
    chk("re_cycles", re_n, e.re);
    chk("we_cycles", we_n, e.we);
    chk("clear_pulses", clr_n, e.clr);
    chk("print_pulses", prt_n, e.prt);
    chk("sel_d", sd1, e.sd);
    chk("sel_i", si1, e.si);
    chk("re_we_overlap", ovl, 0);
    chk("addr_out", a_o, e.addr);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("illegal_clear", illegal, 0);
    chk("ready_after", cmd_ready, 1);
    chk("read_cnt", read_cnt, m_rd);
    chk("write_cnt", write_cnt, m_wr);
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_strobes"}, {sel_d, sel_i, read_enable, write_enable,
                            clear_req, print_req, done, illegal}, 8'h00);
    chk({tag, "_addr"}, addr_out, 0);
    chk({tag, "_cnts"}, {read_cnt, write_cnt, hit_cnt, miss_cnt}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] mix [8];
    bit         saw_done;
    mix = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd0, 4'd9, 4'd2, 4'd1};
    n_chk = 0; n_fail = 0;
    m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
    clk = 0; rst = 0;
    cmd_valid = 0; cmd_n = '0; cmd_addr = '0; hit = 0; hitM = 0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1;
    @(negedge clk);

    // Reset in the middle of a lookup aborts with no done pulse
    cmd_valid = 1; cmd_n = 4'd0; cmd_addr = 32'hDEADBEEF;
    @(negedge clk);
    cmd_valid = 0;
    chk("re_before_abort", read_enable, 1);
    rst = 0;
    #1;
    chk_idle_outputs("abort");
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      saw_done |= done;
    end
    chk("abort_no_done", saw_done, 0);
    rst = 1;
    @(negedge clk);

    run_cmd(4'd0, 32'h984DE132, 1'b0);
    run_cmd(4'd2, 32'h116DE12F, 1'b1);
    run_cmd(4'd3, 32'h00001000, 1'b0);
    run_cmd(4'd3, 32'h00002000, 1'b1);
    run_cmd(4'd4, 32'h00003000, 1'b1);
    run_cmd(4'd4, 32'h00004000, 1'b0);

    // Mixed traffic, then clear wipes the statistics, then print
    foreach (mix[i]) run_cmd(mix[i], $urandom, 1'($urandom_range(0, 1)));
    run_cmd(4'd8, 32'hCAFE0000, 1'b0);
    run_cmd(4'd9, 32'hCAFE0004, 1'b1);

    // Write counter saturates at all-ones, unsupported code is illegal
    repeat (5) run_cmd(4'd1, $urandom, 1'b1);
    chk("write_saturated", write_cnt, CMAX);
    run_cmd(4'hF, 32'h0BADC0DE, 1'b0);
    run_cmd(4'd5, 32'h0BADC0DF, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
